// File: rtl/collision_event_gen_if.sv
// Signal bundle between the sprite compositors, the lives compositor and
// collision_event_gen. The slave side is the event generator.
interface collision_event_gen_if;
  logic       i_v_sync;
  logic       i_player_hit;
  logic       i_obstacle_hit;
  logic       i_out_of_lives;
  logic       o_barrier_hit;
  logic       o_invuln;
  logic       o_player_visible;
  logic [7:0] o_hit_count;

  modport slave (
    input  i_v_sync, i_player_hit, i_obstacle_hit, i_out_of_lives,
    output o_barrier_hit, o_invuln, o_player_visible, o_hit_count
  );

  modport master (
    output i_v_sync, i_player_hit, i_obstacle_hit, i_out_of_lives,
    input  o_barrier_hit, o_invuln, o_player_visible, o_hit_count
  );
endinterface

// File: rtl/collision_event_gen.sv
// Frame-accumulated player/barrier overlap detector that issues a stretched
// barrier_hit pulse followed by a grace window. Define BLINK_EN for player blink.
module collision_event_gen #(
  parameter int unsigned MIN_OVERLAP_PIX = 4,
  parameter int unsigned GRACE_FRAMES    = 60,
  parameter int unsigned PULSE_LEN       = 4,
  parameter int unsigned BLINK_PERIOD    = 8
) (
  input logic                  i_clk,
  input logic                  i_rst,
  collision_event_gen_if.slave bus
);

  localparam logic [15:0] MIN_PIX    = 16'(MIN_OVERLAP_PIX);
  localparam logic [7:0]  GRACE_N    = 8'(GRACE_FRAMES);
  localparam logic [3:0]  PULSE_LAST = 4'(PULSE_LEN - 1);

  typedef enum logic [1:0] {ARMED, PULSE, GRACE, DEAD} state_t;

  state_t      state;
  logic        vs_q;
  logic        vs_rise;
  logic        ov;
  logic        pulse_done;
  logic        grace_done;
  logic [15:0] pix_cnt;
  logic [7:0]  frm_cnt;
  logic [3:0]  pulse_cnt;
  logic        hit_q;
  logic        invuln_q;
  logic [7:0]  hit_count_q;

  assign vs_rise    = bus.i_v_sync & ~vs_q;
  assign ov         = bus.i_player_hit & bus.i_obstacle_hit & ~bus.i_v_sync;
  assign pulse_done = (state == PULSE) && (pulse_cnt == PULSE_LAST);
  assign grace_done = vs_rise && ((frm_cnt + 8'd1) == GRACE_N);

  // Overlap counter runs in every state; the FSM only looks at it in ARMED.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vs_q    <= 1'b0;
      pix_cnt <= '0;
    end else begin
      vs_q <= bus.i_v_sync;
      if (vs_rise)
        pix_cnt <= '0;
      else if (ov && (pix_cnt < MIN_PIX))
        pix_cnt <= pix_cnt + 16'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ARMED;
      hit_q       <= 1'b0;
      invuln_q    <= 1'b0;
      hit_count_q <= '0;
      frm_cnt     <= '0;
      pulse_cnt   <= '0;
    end else begin
      case (state)
        ARMED: begin
          if (bus.i_out_of_lives) begin
            state <= DEAD;
          end else if (vs_rise && (pix_cnt >= MIN_PIX)) begin
            state     <= PULSE;
            hit_q     <= 1'b1;
            pulse_cnt <= '0;
            if (hit_count_q != '1)
              hit_count_q <= hit_count_q + 8'd1;
          end
        end
        // out_of_lives is only acted on once the pulse has run its full length
        PULSE: begin
          if (pulse_done) begin
            hit_q   <= 1'b0;
            frm_cnt <= '0;
            if (bus.i_out_of_lives) begin
              state <= DEAD;
            end else begin
              state    <= GRACE;
              invuln_q <= 1'b1;
            end
          end else begin
            pulse_cnt <= pulse_cnt + 4'd1;
          end
        end
        GRACE: begin
          if (bus.i_out_of_lives) begin
            state    <= DEAD;
            invuln_q <= 1'b0;
          end else if (grace_done) begin
            state    <= ARMED;
            invuln_q <= 1'b0;
            frm_cnt  <= '0;
          end else if (vs_rise) begin
            frm_cnt <= frm_cnt + 8'd1;
          end
        end
        default: begin
          hit_q    <= 1'b0;
          invuln_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_barrier_hit = hit_q;
  assign bus.o_invuln      = invuln_q;
  assign bus.o_hit_count   = hit_count_q;

`ifdef BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_PERIOD - 1);

  logic [7:0] blink_cnt;
  logic       visible_q;

  // Tracks the FSM's GRACE entry/exit conditions so visibility is 0 on entry
  // and 1 again the same cycle invuln drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_cnt <= '0;
      visible_q <= 1'b1;
    end else if (pulse_done && !bus.i_out_of_lives) begin
      blink_cnt <= '0;
      visible_q <= 1'b0;
    end else if (state == GRACE) begin
      if (bus.i_out_of_lives || grace_done) begin
        visible_q <= 1'b1;
      end else if (vs_rise) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          visible_q <= ~visible_q;
        end else begin
          blink_cnt <= blink_cnt + 8'd1;
        end
      end
    end else begin
      visible_q <= 1'b1;
    end
  end

  assign bus.o_player_visible = visible_q;
`else
  assign bus.o_player_visible = 1'b1;
`endif

endmodule

// File: tb/tb_collision_event_gen.sv
// Directed self-checking bench for collision_event_gen (default parameters,
// blink expectations follow BLINK_EN).
module tb_collision_event_gen;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  collision_event_gen_if bus ();

  collision_event_gen #(
    .MIN_OVERLAP_PIX (4),
    .GRACE_FRAMES    (60),
    .PULSE_LEN       (4),
    .BLINK_PERIOD    (8)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Visibility expected k vs_rise edges into grace.
  function automatic int exp_vis(input int k);
`ifdef BLINK_EN
    return (k / 8) % 2;
`else
    return 1 + 0 * k;
`endif
  endfunction

  // One active frame: n overlapping pixels plus single-sprite pixels that must not count.
  task automatic overlap(input int n);
    bus.i_v_sync       = 1'b0;
    bus.i_player_hit   = 1'b1;
    bus.i_obstacle_hit = 1'b0;
    step();
    bus.i_player_hit   = 1'b0;
    bus.i_obstacle_hit = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      bus.i_player_hit   = 1'b1;
      bus.i_obstacle_hit = 1'b1;
      step();
      bus.i_player_hit   = 1'b0;
      bus.i_obstacle_hit = 1'b0;
      step();
    end
    bus.i_player_hit   = 1'b0;
    bus.i_obstacle_hit = 1'b0;
    step();
  endtask

  // Frame boundary; optionally overlaps during the vs_rise cycle. Checks the pulse shape.
  task automatic end_frame(input bit exp_hit, input bit vs_ov);
    bus.i_v_sync       = 1'b1;
    bus.i_player_hit   = vs_ov;
    bus.i_obstacle_hit = vs_ov;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 0) begin
        bus.i_player_hit   = 1'b0;
        bus.i_obstacle_hit = 1'b0;
      end
      if (i == 1) bus.i_v_sync = 1'b0;
      chk($sformatf("pulse[%0d]", i), int'(bus.o_barrier_hit), int'(exp_hit && i < 4));
    end
  endtask

  task automatic do_reset();
    i_rst              = 1'b1;
    bus.i_v_sync       = 1'b0;
    bus.i_player_hit   = 1'b0;
    bus.i_obstacle_hit = 1'b0;
    bus.i_out_of_lives = 1'b0;
    step();
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_hit",   int'(bus.o_barrier_hit),    0);
    chk("rst_inv",   int'(bus.o_invuln),         0);
    chk("rst_vis",   int'(bus.o_player_visible), 1);
    chk("rst_count", int'(bus.o_hit_count),      0);

    // exactly MIN_OVERLAP_PIX pixels -> hit
    overlap(4);
    end_frame(1'b1, 1'b0);
    chk("t1_count", int'(bus.o_hit_count), 1);
    chk("t1_inv",   int'(bus.o_invuln),    1);
    chk("t1_vis",   int'(bus.o_player_visible), exp_vis(0));

    // out_of_lives during GRACE -> DEAD next clock
    bus.i_out_of_lives = 1'b1;
    step();
    chk("grace_dead_inv", int'(bus.o_invuln), 0);
    chk("grace_dead_vis", int'(bus.o_player_visible), 1);

    // MIN-1 pixels per frame never hits; vs_rise-cycle overlap must not top it up
    do_reset();
    for (int f = 0; f < 5; f++) begin
      overlap(3);
      end_frame(1'b0, 1'b1);
    end
    chk("t2_count", int'(bus.o_hit_count), 0);
    chk("t2_inv",   int'(bus.o_invuln),    0);

    // grace window with continuous overlap
    overlap(20);
    end_frame(1'b1, 1'b0);
    chk("t3_count1", int'(bus.o_hit_count), 1);
    for (int k = 1; k <= 60; k++) begin
      overlap(20);
      end_frame(1'b0, 1'b0);
      chk($sformatf("t3_inv_f%0d", k), int'(bus.o_invuln), (k < 60) ? 1 : 0);
      if (k % 8 == 0 || k == 60)
        chk($sformatf("t3_vis_f%0d", k), int'(bus.o_player_visible),
            (k < 60) ? exp_vis(k) : 1);
    end
    chk("t3_count_mid", int'(bus.o_hit_count), 1);
    overlap(20);
    end_frame(1'b1, 1'b0);
    chk("t3_count2", int'(bus.o_hit_count), 2);

    // out_of_lives mid-PULSE: pulse completes, then DEAD for good
    do_reset();
    overlap(4);
    bus.i_v_sync = 1'b1;
    step();
    chk("t4_p0", int'(bus.o_barrier_hit), 1);
    bus.i_out_of_lives = 1'b1;
    for (int i = 1; i < 4; i++) begin
      step();
      if (i == 1) bus.i_v_sync = 1'b0;
      chk($sformatf("t4_p%0d", i), int'(bus.o_barrier_hit), 1);
    end
    step();
    chk("t4_pend", int'(bus.o_barrier_hit), 0);
    chk("t4_inv",  int'(bus.o_invuln),      0);
    bus.i_out_of_lives = 1'b0;
    for (int f = 0; f < 2; f++) begin
      overlap(10);
      end_frame(1'b0, 1'b0);
    end
    chk("t4_dead_inv",   int'(bus.o_invuln),         0);
    chk("t4_dead_vis",   int'(bus.o_player_visible), 1);
    chk("t4_dead_count", int'(bus.o_hit_count),      1);

    // reset on the 2nd pulse clock
    do_reset();
    overlap(4);
    bus.i_v_sync = 1'b1;
    step();
    step();
    chk("t5_p1", int'(bus.o_barrier_hit), 1);
    i_rst        = 1'b1;
    bus.i_v_sync = 1'b0;
    step();
    chk("t5_hit",   int'(bus.o_barrier_hit),    0);
    chk("t5_count", int'(bus.o_hit_count),      0);
    chk("t5_inv",   int'(bus.o_invuln),         0);
    chk("t5_vis",   int'(bus.o_player_visible), 1);
    i_rst = 1'b0;
    overlap(4);
    end_frame(1'b1, 1'b0);
    chk("t5_rearm_count", int'(bus.o_hit_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
